// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin arbiter sharing one uart_tx between NUM_REQ producers.
//            Optional macro UART_TX_ARB_ID_BYTE_EN prefixes each payload with
//            a channel ID word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
    parameter int DATA_SIZE = 8,
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_SIZE-1:0]  req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          tx_start,
    output logic [DATA_SIZE-1:0]          data_out,
    input  logic                          tx_done_tick,
    output logic                          busy,
    output logic [ID_W-1:0]               grant_id
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_DATA = 2'd1
`ifdef UART_TX_ARB_ID_BYTE_EN
        ,
        S_SEND_ID   = 2'd2,
        S_WAIT_ID   = 2'd3
`endif
    } state_t;

    localparam logic [ID_W:0]   C_NUM_REQ_EXT = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] C_LAST_CH     = ID_W'(NUM_REQ - 1);

    state_t                r_state;
    logic [ID_W-1:0]       r_ptr;
    logic                  w_found;
    logic [ID_W-1:0]       w_winner;
    logic [ID_W:0]         w_idx;
    logic [DATA_SIZE-1:0]  w_sel_data;
    logic [ID_W-1:0]       w_next_ptr;
`ifdef UART_TX_ARB_ID_BYTE_EN
    logic [DATA_SIZE-1:0]  r_payload;
    logic [DATA_SIZE-1:0]  w_id_word;
`endif

    // Scan from the highest offset down so the lowest offset from r_ptr wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_ptr} + (ID_W+1)'(k);
            if (w_idx >= C_NUM_REQ_EXT) begin
                w_idx = w_idx - C_NUM_REQ_EXT;
            end
            if (req[w_idx[ID_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == ID_W'(i)) begin
                w_sel_data = req_data[i*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    assign w_next_ptr = (grant_id == C_LAST_CH) ? '0 : grant_id + 1'b1;

`ifdef UART_TX_ARB_ID_BYTE_EN
    always_comb begin
        w_id_word                = '0;
        w_id_word[DATA_SIZE-1]   = 1'b1;
        w_id_word[ID_W-1:0]      = w_winner;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            ack       <= '0;
            tx_start  <= 1'b0;
            data_out  <= '0;
            busy      <= 1'b0;
            grant_id  <= '0;
`ifdef UART_TX_ARB_ID_BYTE_EN
            r_payload <= '0;
`endif
        end else begin
            ack      <= '0;
            tx_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        ack      <= NUM_REQ'(1) << w_winner;
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                        grant_id <= w_winner;
`ifdef UART_TX_ARB_ID_BYTE_EN
                        r_payload <= w_sel_data;
                        data_out  <= w_id_word;
                        r_state   <= S_WAIT_ID;
`else
                        data_out <= w_sel_data;
                        r_state  <= S_WAIT_DATA;
`endif
                    end
                end
`ifdef UART_TX_ARB_ID_BYTE_EN
                S_WAIT_ID: begin
                    if (tx_done_tick) begin
                        r_state <= S_SEND_ID;
                    end
                end
                S_SEND_ID: begin
                    data_out <= r_payload;
                    tx_start <= 1'b1;
                    r_state  <= S_WAIT_DATA;
                end
`endif
                S_WAIT_DATA: begin
                    if (tx_done_tick) begin
                        busy    <= 1'b0;
                        r_ptr   <= w_next_ptr;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Scoreboard bench for uart_tx_arbiter with a behavioural uart_tx.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

    localparam int DW    = 8;
    localparam int NR    = 4;
    localparam int FRAME = 6;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NR-1:0] req = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR-1:0] ack;
    logic          tx_start;
    logic [DW-1:0] data_out;
    logic          tx_done_tick = 1'b0;
    logic          busy;
    logic [1:0]    grant_id;

    logic          force_tick = 1'b0;
    int            cnt = 0;
    int            tests = 0;
    int            fails = 0;
    int            ack_cnt [NR];
    int            rearm0 = 0;

    typedef struct {
        logic [DW-1:0] d;
        int            ch;
        logic [NR-1:0] a;
    } exp_t;
    exp_t sbq[$];

    uart_tx_arbiter #(.DATA_SIZE(DW), .NUM_REQ(NR)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data),
        .ack(ack), .tx_start(tx_start), .data_out(data_out),
        .tx_done_tick(tx_done_tick), .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    // Behavioural uart_tx: done pulse FRAME cycles after each start.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt = 0;
            tx_done_tick = 1'b0;
        end else begin
            #2;
            tx_done_tick = force_tick;
            if (cnt > 0) begin
                cnt = cnt - 1;
                if (cnt == 0) tx_done_tick = 1'b1;
            end else if (tx_start) begin
                cnt = FRAME;
            end
        end
    end

    task automatic push_grant(input int ch, input logic [DW-1:0] d);
        exp_t e;
        e.ch = ch;
`ifdef UART_TX_ARB_ID_BYTE_EN
        e.d = 8'h80 | DW'(ch);
        e.a = NR'(1) << ch;
        sbq.push_back(e);
        e.d = d;
        e.a = '0;
        sbq.push_back(e);
`else
        e.d = d;
        e.a = NR'(1) << ch;
        sbq.push_back(e);
`endif
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                tests++;
                if (sbq.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_start: data=%h grant=%0d ack=%b, none expected",
                             data_out, grant_id, ack);
                end else begin
                    e = sbq.pop_front();
                    if (data_out !== e.d || grant_id !== 2'(e.ch) || ack !== e.a) begin
                        fails++;
                        $display("FAIL frame: got data=%h grant=%0d ack=%b, want data=%h grant=%0d ack=%b",
                                 data_out, grant_id, ack, e.d, e.ch, e.a);
                    end
                end
            end else if (ack != '0) begin
                tests++;
                fails++;
                $display("FAIL ack_without_start: ack=%b, want 0000", ack);
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // Advance one cycle; requesters drop req in the cycle they see ack.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            if (ack[i]) ack_cnt[i]++;
        end
        req = req & ~ack;
        if (ack[0] && rearm0 > 0) begin
            rearm0--;
            req[0] = 1'b1;
        end
    endtask

    task automatic set_data(input int ch, input logic [DW-1:0] d);
        req_data[ch*DW +: DW] = d;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((sbq.size() != 0 || busy || req != '0) && n < 400) begin
            step();
            n++;
        end
        tests++;
        if (n >= 400) begin
            fails++;
            $display("FAIL %s_timeout: %0d frames outstanding, want 0", name, sbq.size());
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < NR; i++) ack_cnt[i] = 0;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_ack", 32'(ack), 32'h0);
        check("reset_tx_start", 32'(tx_start), 32'h0);
        check("reset_data_out", 32'(data_out), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_grant_id", 32'(grant_id), 32'h0);
        reset_n = 1'b1;
        step();

        // Single request on ch2
        set_data(2, 8'hCB);
        push_grant(2, 8'hCB);
        req = 4'b0100;
        step();
        check("single_busy", 32'(busy), 32'h1);
`ifndef UART_TX_ARB_ID_BYTE_EN
        n = 0;
        while (!tx_done_tick && n < 50) begin step(); n++; end
        check("single_busy_at_done", 32'(busy), 32'h1);
        step();
        check("single_busy_after_done", 32'(busy), 32'h0);
`endif
        wait_drain("single");
        check("single_ack_cnt", 32'(ack_cnt[2]), 32'h1);

        // All four from reset
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < NR; i++) ack_cnt[i] = 0;
        set_data(0, 8'h10); set_data(1, 8'h21); set_data(2, 8'h32); set_data(3, 8'h43);
        push_grant(0, 8'h10); push_grant(1, 8'h21);
        push_grant(2, 8'h32); push_grant(3, 8'h43);
        req = 4'b1111;
        wait_drain("all4");
        for (int i = 0; i < NR; i++) check("all4_ack_cnt", 32'(ack_cnt[i]), 32'h1);

        // Fairness: ch0 re-requests after each ack, ch3 once
        set_data(0, 8'hA5); set_data(3, 8'h5A);
        push_grant(0, 8'hA5); push_grant(3, 8'h5A);
        push_grant(0, 8'hA5); push_grant(0, 8'hA5);
        rearm0 = 2;
        req = 4'b1001;
        wait_drain("fair");

        // Spurious done tick in IDLE, then req toggling during WAIT_DATA
        force_tick = 1'b1;
        step();
        force_tick = 1'b0;
        repeat (3) step();
        check("spurious_busy", 32'(busy), 32'h0);
        set_data(1, 8'h3C);
        push_grant(1, 8'h3C);
        req = 4'b0010;
        step();
        step();
        set_data(2, 8'h77);
        req[2] = 1'b1;
        step();
        req[2] = 1'b0;
        step();
        check("toggle_busy", 32'(busy), 32'h1);
        wait_drain("toggle");

        // Async reset mid-frame on ch1
        set_data(1, 8'h96);
        push_grant(1, 8'h96);
        req = 4'b0010;
        step();
        step();
        step();
        #2 reset_n = 1'b0;
        #1;
        check("midreset_outputs", {25'b0, ack, tx_start, busy, grant_id},  32'h0);
        check("midreset_data_out", 32'(data_out), 32'h0);
        sbq.delete();
        @(negedge clk);
        reset_n = 1'b1;
        set_data(0, 8'hE0); set_data(1, 8'hE1); set_data(2, 8'hE2); set_data(3, 8'hE3);
        push_grant(0, 8'hE0); push_grant(1, 8'hE1);
        push_grant(2, 8'hE2); push_grant(3, 8'hE3);
        req = 4'b1111;
        wait_drain("postreset");
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `uart_tx` transmitter between `NUM_REQ` byte producers. It sits between the requesters (FIFOs or protocol blocks) and `uart_tx`. It grants one requester at a time and latches that requester's word. It pulses `tx_start` with the word on `data_out`, then holds off further grants until `uart_tx` returns `tx_done_tick`. It has no baud logic of its own; serial timing comes entirely from `uart_tx` and `uart_sampling_tick`.

## Interface
- `DATA_SIZE`, 8: width of one transmitted word; must match `uart_tx`.
- `NUM_REQ`, 4: number of requesters, 2..16.
- `ID_W`, `$clog2(NUM_REQ)`: width of the channel index.

Ports:
- `clk`  in  1: system clock; all state is updated on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `req`  in  `NUM_REQ`: request per channel; level-held by the requester until it sees `ack`.
- `req_data`  in  `NUM_REQ*DATA_SIZE`: word for channel i at bits `[i*DATA_SIZE +: DATA_SIZE]`; stable while `req[i]`=1.
- `ack`  out  `NUM_REQ`: one-hot, one-cycle pulse; the word of that channel has been consumed.
- `tx_start`  out  1: one-cycle start pulse to `uart_tx`.
- `data_out`  out  `DATA_SIZE`: word to `uart_tx.data_in`; stable from the `tx_start` cycle until `tx_done_tick`.
- `tx_done_tick`  in  1: end-of-frame pulse from `uart_tx`.
- `busy`  out  1: high while a frame is in flight.
- `grant_id`  out  `ID_W`: index of the last granted channel.

## Operation
- States: IDLE, WAIT_DATA (plus SEND_ID and WAIT_ID with the macro).
- Round-robin pointer `ptr` (`ID_W` bits): the search order is `ptr`, `ptr+1`, … modulo `NUM_REQ`. The first channel with `req` high wins.
- IDLE with any `req` high, at the clock edge:
  - latch `req_data[winner]` into `data_out`;
  - set `ack[winner]`=1, `tx_start`=1, `busy`=1 and `grant_id`=winner;
  - go to WAIT_DATA.
- The next edge always clears `ack` and `tx_start`; both are exactly one cycle wide.
- WAIT_DATA, when `tx_done_tick`=1 is sampled:
  - go to IDLE, `busy`=0;
  - `ptr` = (winner+1) mod `NUM_REQ`, with explicit wrap (`NUM_REQ` need not be a power of two).
- `req` and `req_data` are ignored outside IDLE. A `req` still high when the arbiter is back in IDLE counts as a new request, so a requester drops `req` in the cycle it sees `ack`.
- `tx_done_tick` in IDLE is ignored; it has no state change.
- A `req` withdrawn before `ack` is never granted or latched.
- Reset (asynchronous, any state): state=IDLE, `ptr`=0, `ack`=0, `tx_start`=0, `data_out`=0, `busy`=0, `grant_id`=0. A frame in flight is abandoned; `uart_tx` shares `reset_n`.

## Timing
- Grant latency: `req` sampled high in IDLE at edge k → `ack`, `tx_start` and `data_out` valid in cycle k+1.
- Release: `tx_done_tick` sampled at edge m → IDLE and `busy`=0 in cycle m+1. The earliest next `tx_start` is cycle m+2 (one idle cycle between frames).
- Throughput: one word per (`uart_tx` frame + 2 cycles); the `uart_tx` frame is 10 bits × 16 × `BAUD_DVSR` clocks at 8N1.

## Configuration
- `UART_TX_ARB_ID_BYTE_EN`, defined: each grant sends two frames, a channel ID word then the payload.
  - The ID word is MSB=1, low `ID_W` bits = winner index, all other bits 0. Example for ch2 with `DATA_SIZE`=8: 8'h82.
  - Sequence:
    - IDLE grant: latch payload, pulse `ack`, drive `data_out`=ID, `tx_start`=1, go to WAIT_ID.
    - `tx_done_tick` in WAIT_ID: go to SEND_ID.
    - SEND_ID: `data_out`=latched payload, `tx_start`=1 for one cycle, go to WAIT_DATA.
    - WAIT_DATA: as above.
  - `busy` stays high across both frames.
  - Requires `DATA_SIZE` > `ID_W`.
- Not defined: one frame per grant. SEND_ID and WAIT_ID are absent.

## Test plan
- Single request: `NUM_REQ`=4, `req`=4'b0100, ch2 data 8'hCB → next cycle `ack`=4'b0100, `tx_start`=1, `data_out`=8'hCB, `grant_id`=2. Serial line carries 0xCB LSB-first. `busy` falls one cycle after `tx_done_tick`.
- All four requesting from reset, with data 8'h10/8'h21/8'h32/8'h43 → frames sent in order ch0, ch1, ch2, ch3. Exactly one `ack` per channel.
- Fairness: ch0 re-asserts `req` immediately after every `ack`; ch3 requests once → ch3 is granted directly after ch0's first frame, never starved.
- Spurious `tx_done_tick` in IDLE, and `req` toggled while in WAIT_DATA → no `ack`, no `tx_start`, state unchanged.
- Assert `reset_n`=0 mid-frame (WAIT_DATA, ch1) → all outputs 0 immediately. After release with `req`=4'b1111, the first grant goes to ch0.
- With `UART_TX_ARB_ID_BYTE_EN`: ch2 requests 8'hCB → frames 8'h82 then 8'hCB, one `ack`, two `tx_start` pulses. `busy` stays high from the first `tx_start` to the second `tx_done_tick`+1.
